// File: rtl/l6_mac_sequencer.sv
// Layer-6 MAC/adder-tree sequencer: streams CIN_GROUPS beats per output pixel and flags each result.
// Optional macro L6_SEQ_PERF_EN adds the stall_cnt performance counter output.
module l6_mac_sequencer #(
   parameter int M          = 4,
   parameter int CIN_GROUPS = 16,
   parameter int NUM_PIXELS = 64,
   parameter int PIPE_LAT   = 3,
   parameter int GA_W       = 4,
   parameter int PA_W       = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            acc_en,
   output logic            load,
   output logic [GA_W-1:0] w_grp,
   output logic [PA_W-1:0] d_pix,
   output logic            skip_rd_en,
   output logic [PA_W-1:0] skip_pix,
   output logic            out_valid,
   output logic [PA_W-1:0] out_pix,
   output logic            busy,
   output logic            done
`ifdef L6_SEQ_PERF_EN
   ,
   output logic [15:0]     stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_reg, state_next;

   logic [GA_W-1:0] grp_reg;
   logic [PA_W-1:0] pix_reg;

   logic start_ok;
   logic beat;
   logic last_grp;
   logic last_pix;
   logic mark_vld;
   logic drain_pend;

   logic [PIPE_LAT-1:0] stage_vld_reg;
   logic [PA_W-1:0]     stage_pix_reg [PIPE_LAT];

   // M only sizes the downstream array; a non-positive value is a configuration error.
   generate
      if (M < 1) begin : g_bad_m
      end
   endgenerate

   assign start_ok = (state_reg == S_IDLE) && start;
   assign in_ready = (state_reg == S_RUN);
   assign beat     = in_ready && in_valid;
   assign last_grp = (grp_reg == GA_W'(CIN_GROUPS - 1));
   assign last_pix = (pix_reg == PA_W'(NUM_PIXELS - 1));
   assign mark_vld = beat && last_grp;

   assign acc_en = beat;
   assign load   = beat && (grp_reg == '0);
   assign w_grp  = grp_reg;
   assign d_pix  = pix_reg;

   assign out_valid = stage_vld_reg[PIPE_LAT-1];
   assign out_pix   = stage_pix_reg[PIPE_LAT-1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (mark_vld && last_pix) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave as the final marker reaches the output, so done follows out_valid by one cycle.
            busy = 1'b1;
            if (!drain_pend) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         grp_reg <= '0;
         pix_reg <= '0;
      end else if (start_ok) begin
         grp_reg <= '0;
         pix_reg <= '0;
      end else if (beat) begin
         if (last_grp) begin
            grp_reg <= '0;
            pix_reg <= last_pix ? '0 : pix_reg + 1'b1;
         end else begin
            grp_reg <= grp_reg + 1'b1;
         end
      end
   end

   // Result markers advance every cycle regardless of input stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stage_vld_reg <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            stage_pix_reg[i] <= '0;
         end
      end else begin
         stage_vld_reg[0] <= mark_vld;
         stage_pix_reg[0] <= mark_vld ? pix_reg : '0;
         for (int i = 1; i < PIPE_LAT; i++) begin
            stage_vld_reg[i] <= stage_vld_reg[i-1];
            stage_pix_reg[i] <= stage_pix_reg[i-1];
         end
      end
   end

   generate
      if (PIPE_LAT == 1) begin : g_lat1
         assign skip_rd_en = mark_vld;
         assign skip_pix   = mark_vld ? pix_reg : '0;
         assign drain_pend = 1'b0;
      end else begin : g_latn
         assign skip_rd_en = stage_vld_reg[PIPE_LAT-2];
         assign skip_pix   = stage_pix_reg[PIPE_LAT-2];
         assign drain_pend = |stage_vld_reg[PIPE_LAT-2:0];
      end
   endgenerate

`ifdef L6_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (start_ok) begin
         stall_cnt <= '0;
      end else if (in_ready && !in_valid && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l6_mac_sequencer.sv
// Self-checking bench for l6_mac_sequencer: two configurations checked cycle by cycle against a beat/schedule model.
module tb_l6_mac_sequencer;

   localparam int GA = 4;
   localparam int PA = 2;
   localparam int LA = 3;
   localparam int GB = 1;
   localparam int PB = 3;
   localparam int LB = 3;
   localparam int MAXC = 200;

   logic clk = 1'b0;
   logic rst;
   logic start_a;
   logic start_b;
   logic in_valid;

   logic       a_in_ready, a_acc_en, a_load, a_skip_rd_en, a_out_valid, a_busy, a_done;
   logic [3:0] a_w_grp;
   logic [5:0] a_d_pix, a_skip_pix, a_out_pix;
   logic       b_in_ready, b_acc_en, b_load, b_skip_rd_en, b_out_valid, b_busy, b_done;
   logic [3:0] b_w_grp;
   logic [5:0] b_d_pix, b_skip_pix, b_out_pix;
`ifdef L6_SEQ_PERF_EN
   logic [15:0] a_stall_cnt;
   logic [15:0] b_stall_cnt;
`endif

   logic       sel_b = 1'b0;
   logic       m_in_ready, m_acc_en, m_load, m_skip_rd_en, m_out_valid, m_busy, m_done;
   logic [3:0] m_w_grp;
   logic [5:0] m_d_pix, m_skip_pix, m_out_pix;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   l6_mac_sequencer #(.M(4), .CIN_GROUPS(GA), .NUM_PIXELS(PA), .PIPE_LAT(LA), .GA_W(4), .PA_W(6)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(a_in_ready),
      .acc_en(a_acc_en), .load(a_load), .w_grp(a_w_grp), .d_pix(a_d_pix),
      .skip_rd_en(a_skip_rd_en), .skip_pix(a_skip_pix), .out_valid(a_out_valid), .out_pix(a_out_pix),
      .busy(a_busy), .done(a_done)
`ifdef L6_SEQ_PERF_EN
      , .stall_cnt(a_stall_cnt)
`endif
   );

   l6_mac_sequencer #(.M(4), .CIN_GROUPS(GB), .NUM_PIXELS(PB), .PIPE_LAT(LB), .GA_W(4), .PA_W(6)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(b_in_ready),
      .acc_en(b_acc_en), .load(b_load), .w_grp(b_w_grp), .d_pix(b_d_pix),
      .skip_rd_en(b_skip_rd_en), .skip_pix(b_skip_pix), .out_valid(b_out_valid), .out_pix(b_out_pix),
      .busy(b_busy), .done(b_done)
`ifdef L6_SEQ_PERF_EN
      , .stall_cnt(b_stall_cnt)
`endif
   );

   assign m_in_ready   = sel_b ? b_in_ready   : a_in_ready;
   assign m_acc_en     = sel_b ? b_acc_en     : a_acc_en;
   assign m_load       = sel_b ? b_load       : a_load;
   assign m_skip_rd_en = sel_b ? b_skip_rd_en : a_skip_rd_en;
   assign m_out_valid  = sel_b ? b_out_valid  : a_out_valid;
   assign m_busy       = sel_b ? b_busy       : a_busy;
   assign m_done       = sel_b ? b_done       : a_done;
   assign m_w_grp      = sel_b ? b_w_grp      : a_w_grp;
   assign m_d_pix      = sel_b ? b_d_pix      : a_d_pix;
   assign m_skip_pix   = sel_b ? b_skip_pix   : a_skip_pix;
   assign m_out_pix    = sel_b ? b_out_pix    : a_out_pix;

   // Runs one tile on the selected instance. Model: beat k addresses group k%G of pixel k/G; the
   // last group of a pixel schedules out_valid L cycles later, skip read one cycle before that,
   // and done one cycle after the final result.
   task automatic drive_tile(input bit use_b, input int rand_pct, input int stall_after,
                             input int stall_len, input bit noise, input int abort_beat,
                             output int stalls);
      int g, p, lat, n, k, done_cycle, stall_left;
      int out_sched[MAXC+8];
      int skip_sched[MAXC+8];
      bit iv, running, beat_now, abort_now;
      logic e_ov, e_sk;
      logic [3:0] e_wg;
      logic [5:0] e_dp, e_op, e_sp;
      logic [28:0] exp_v, got_v;
      g   = use_b ? GB : GA;
      p   = use_b ? PB : PA;
      lat = use_b ? LB : LA;
      n   = g * p;
      for (int i = 0; i < MAXC + 8; i++) begin
         out_sched[i]  = -1;
         skip_sched[i] = -1;
      end
      sel_b = use_b;
      k = 0;
      done_cycle = MAXC;
      stall_left = 0;
      stalls = 0;
      for (int c = 0; c < MAXC; c++) begin
         @(posedge clk);
         #1;
         running = (c > 0) && (k < n);
         iv = 1'b1;
         if (rand_pct > 0 && int'($urandom_range(99)) < rand_pct) iv = 1'b0;
         if (stall_left > 0) begin
            iv = 1'b0;
            stall_left--;
         end
         abort_now = (abort_beat >= 0) && running && (k == abort_beat);
         in_valid = iv;
         rst      = !abort_now;
         start_a  = (c == 0) && !use_b;
         start_b  = (c == 0) && use_b;
         if (noise && c > 0 && c <= done_cycle && $urandom_range(3) == 0) begin
            if (use_b) start_b = 1'b1;
            else       start_a = 1'b1;
         end
         beat_now = running && iv;
         if (running && !iv) stalls++;
         if (beat_now && (k % g == g - 1)) begin
            out_sched[c + lat]      = k / g;
            skip_sched[c + lat - 1] = k / g;
            if (k == n - 1) done_cycle = c + lat + 1;
         end
         @(negedge clk);
         e_ov  = (out_sched[c] >= 0);
         e_sk  = (skip_sched[c] >= 0);
         e_wg  = running ? 4'(k % g) : 4'd0;
         e_dp  = running ? 6'(k / g) : 6'd0;
         e_op  = e_ov ? 6'(out_sched[c]) : 6'd0;
         e_sp  = e_sk ? 6'(skip_sched[c]) : 6'd0;
         exp_v = {running, beat_now, beat_now && (k % g == 0), (c >= 1) && (c < done_cycle),
                  (c == done_cycle), e_ov, e_sk, e_wg, e_dp, e_op, e_sp};
         got_v = {m_in_ready, m_acc_en, m_load, m_busy, m_done, m_out_valid, m_skip_rd_en,
                  running ? m_w_grp : 4'd0, running ? m_d_pix : 6'd0,
                  e_ov ? m_out_pix : 6'd0, e_sk ? m_skip_pix : 6'd0};
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL tile_cycle inst=%0d c=%0d got=%h exp=%h", use_b, c, got_v, exp_v);
         end
         if (beat_now) begin
            if (k == stall_after) stall_left = stall_len;
            k++;
         end
         if (abort_now) begin
            for (int j = 0; j < 6; j++) begin
               @(posedge clk);
               #1;
               rst = 1'b1;
               in_valid = 1'b1;
               start_a = 1'b0;
               start_b = 1'b0;
               @(negedge clk);
               got_v = {m_in_ready, m_acc_en, m_load, m_busy, m_done, m_out_valid, m_skip_rd_en,
                        m_w_grp, m_d_pix, m_out_pix, m_skip_pix};
               checks++;
               if (got_v !== 29'd0) begin
                  failures++;
                  $display("FAIL abort_quiet inst=%0d j=%0d got=%h exp=0", use_b, j, got_v);
               end
            end
            $display("tile inst=%0d aborted at beat %0d", use_b, abort_beat);
            return;
         end
         if (c == done_cycle + 2) begin
            start_a = 1'b0;
            start_b = 1'b0;
            $display("tile inst=%0d beats=%0d stalls=%0d done_cycle=%0d", use_b, n, stalls, done_cycle);
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL tile_timeout inst=%0d got=no_done exp=done_within_%0d", use_b, MAXC);
   endtask

   task automatic test_reset();
      logic [28:0] va, vb;
      rst = 1'b0;
      in_valid = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         va = {a_in_ready, a_acc_en, a_load, a_busy, a_done, a_out_valid, a_skip_rd_en,
               a_w_grp, a_d_pix, a_out_pix, a_skip_pix};
         vb = {b_in_ready, b_acc_en, b_load, b_busy, b_done, b_out_valid, b_skip_rd_en,
               b_w_grp, b_d_pix, b_out_pix, b_skip_pix};
         checks++;
         if (va !== 29'd0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0", va);
         end
         checks++;
         if (vb !== 29'd0) begin
            failures++;
            $display("FAIL reset_b got=%h exp=0", vb);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
   endtask

   task automatic test_basic();
      int st;
      drive_tile(1'b0, 0, -1, 0, 1'b0, -1, st);
      checks++;
      if (a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_idle got=%b%b exp=00", a_in_ready, a_busy);
      end
   endtask

   task automatic test_stall();
      int st;
      drive_tile(1'b0, 0, 2, 2, 1'b0, -1, st);
      drive_tile(1'b0, 35, -1, 0, 1'b0, -1, st);
      checks++;
      if (a_acc_en !== 1'b0) begin
         failures++;
         $display("FAIL stall_idle_acc got=%b exp=0", a_acc_en);
      end
   endtask

   task automatic test_single_group();
      int st;
      drive_tile(1'b1, 0, -1, 0, 1'b0, -1, st);
      drive_tile(1'b1, 40, -1, 0, 1'b0, -1, st);
      checks++;
      if (b_done !== 1'b0 || b_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_idle got=%b%b exp=00", b_done, b_out_valid);
      end
   endtask

   task automatic test_abort();
      int st;
      drive_tile(1'b0, 0, -1, 0, 1'b0, 1 * GA + 2, st);
      drive_tile(1'b0, 0, -1, 0, 1'b0, -1, st);
      checks++;
      if (a_busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_recover_busy got=%b exp=0", a_busy);
      end
   endtask

   task automatic test_start_ignored();
      int st;
      drive_tile(1'b0, 20, -1, 0, 1'b1, -1, st);
      drive_tile(1'b1, 20, -1, 0, 1'b1, -1, st);
      checks++;
      if (a_done !== 1'b0 || b_done !== 1'b0) begin
         failures++;
         $display("FAIL start_ignored_done got=%b%b exp=00", a_done, b_done);
      end
   endtask

   task automatic test_back_to_back();
      int st;
      for (int t = 0; t < 4; t++) begin
         drive_tile(1'b0, int'($urandom_range(50)), -1, 0, 1'b1, -1, st);
         drive_tile(1'b1, int'($urandom_range(50)), -1, 0, 1'b1, -1, st);
      end
   endtask

`ifdef L6_SEQ_PERF_EN
   task automatic test_perf();
      int st;
      drive_tile(1'b0, 0, 2, 5, 1'b0, -1, st);
      checks++;
      if (a_stall_cnt !== 16'(st)) begin
         failures++;
         $display("FAIL perf_count got=%0d exp=%0d", a_stall_cnt, st);
      end
      @(posedge clk);
      #1;
      start_a = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      @(negedge clk);
      checks++;
      if (a_stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL perf_clear got=%0d exp=0", a_stall_cnt);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask
`endif

   initial begin
      rst = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      in_valid = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_single_group();
      test_abort();
      test_start_ignored();
      test_back_to_back();
`ifdef L6_SEQ_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
